spi_txn_arbiter: RTL and testbench
==================================

// Module: spi_txn_arbiter
// PURPOSE
//  Shares one SPI byte-transmit engine among NUM_REQ requesters using round-robin arbitration.
//  Latches the winner's byte and issues a single-cycle start to the engine, then waits for done.
//  Returns a per-requester ack, or an error pulse if the engine fails to answer within TIMEOUT.
//  Sits between client logic and the SPI FSM; enforces a CS-idle gap between transactions.
// PARAMETERS
//  NUM_REQ     4    number of requesters (>=1)
//  GAP_CYCLES  8    idle clk cycles between transactions (0 = no gap)
//  TIMEOUT     256  max clk cycles in WAIT before abort (>=2)
//  SEL_W       max(1,$clog2(NUM_REQ))  derived; width of index outputs
// PORTS
//  clk        in   1            system clock, all logic on posedge
//  rst        in   1            synchronous reset, active-high
//  req        in   NUM_REQ      level request per requester; hold until ack or err
//  wdata      in   8*NUM_REQ    byte per requester, wdata[8*i+7:8*i] for requester i
//  ack        out  NUM_REQ      1-cycle pulse on the granted bit when its byte completed
//  err        out  1            1-cycle pulse on timeout abort
//  err_id     out  SEL_W        index of aborted requester, valid with err
//  busy       out  1            high in every state except IDLE
//  m_start    out  1            1-cycle start pulse to SPI engine
//  m_data     out  8            byte for engine; stable from m_start until next launch
//  m_sel      out  SEL_W        granted requester index (drives CS select); stable likewise
//  m_done     in   1            1-cycle pulse from engine: byte finished, CS released
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, rr_ptr=0, timer=0, m_start=0, m_data=0,
//    m_sel=0, ack=0, err=0, err_id=0, busy=0.
//  - States: IDLE, LAUNCH, WAIT, GAP.
//  - IDLE: if |req, pick first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; latch
//    index into m_sel, its byte into m_data; -> LAUNCH. No req: stay.
//  - LAUNCH: m_start=1 for exactly this cycle; timer cleared; -> WAIT.
//    Latency: req sampled at edge T in IDLE -> m_start high in cycle T+1..T+2 (one cycle).
//  - WAIT: timer increments each cycle. m_done=1 -> ack[m_sel]=1 next cycle,
//    rr_ptr=(m_sel+1) mod NUM_REQ, -> GAP. Else timer==TIMEOUT-1 -> err=1, err_id=m_sel,
//    rr_ptr=(m_sel+1) mod NUM_REQ, -> GAP. m_done and timeout in same cycle: done wins, no err.
//  - GAP: count GAP_CYCLES cycles, then -> IDLE. GAP_CYCLES=0: WAIT goes straight to IDLE.
//  - m_done outside WAIT ignored. req changes after latching do not affect the in-flight
//    transaction; ack still pulses if the requester dropped req.
//  - ack/err are mutually exclusive; at most one ack bit high at any cycle.
//  - Pointer wraps NUM_REQ-1 -> 0. NUM_REQ=1: rr_ptr constant 0, m_sel=0.
//  - Minimum transaction spacing: m_start to next m_start >= 3+GAP_CYCLES cycles.
//  - rst mid-operation: immediate return to IDLE with reset values; no ack/err emitted;
//    a pending m_done after reset is ignored.
//  - timer width $clog2(TIMEOUT)+1; gap counter width $clog2(GAP_CYCLES+1); no overflow.
// TESTING
//  1 req=0001, wdata[7:0]=8'hEA, engine done 20 cyc after start -> m_start 1 cyc,
//    m_data=EA, m_sel=0, ack=0001 1 cyc after done, busy low after 8-cycle gap.
//  2 req=0101 held, bytes 11/33 -> grants 0 then 2 then 0 then 2, ack each, 8-cyc gaps.
//  3 req=1111 held for 8 transactions from rr_ptr=0 -> order 0,1,2,3,0,1,2,3; no starvation.
//  4 req=0010, engine never sends done -> err=1, err_id=1 at WAIT cycle 256, no ack,
//    next grant starts at index 2.
//  5 m_done arrives exactly on WAIT cycle TIMEOUT-1 -> ack pulses, err stays 0.
//  6 rst pulse during WAIT, then m_done -> all outputs at reset values, no ack, IDLE;
//    new req accepted next cycle, grants from index 0.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI byte engine with timeout and CS-idle gap
module spi_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT = 256,
  parameter int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic [SEL_W-1:0]     err_id,
  output logic                 busy,
  output logic                 m_start,
  output logic [7:0]           m_data,
  output logic [SEL_W-1:0]     m_sel,
  input  logic                 m_done
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;
  state_t state, state_d;
  logic [SEL_W-1:0] rr_ptr, rr_d, win, nxt, m_sel_d, err_id_d;
  logic [SEL_W:0] idx;
  logic [TW-1:0] timer, timer_d;
  logic [GW-1:0] gcnt, gcnt_d;
  logic [7:0] m_data_d;
  logic [NUM_REQ-1:0] ack_d;
  logic m_start_d, err_d;
  // descending scan so the requester closest to rr_ptr is written last and wins
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (SEL_W+1)'(i);
      if (idx >= (SEL_W+1)'(NUM_REQ)) idx = idx - (SEL_W+1)'(NUM_REQ);
      if (req[idx[SEL_W-1:0]]) win = idx[SEL_W-1:0];
    end
  end
  assign nxt = (m_sel == SEL_W'(NUM_REQ - 1)) ? '0 : m_sel + 1'b1;
  always_comb begin
    state_d = state;
    rr_d = rr_ptr;
    timer_d = timer;
    gcnt_d = gcnt;
    m_sel_d = m_sel;
    m_data_d = m_data;
    m_start_d = 1'b0;
    ack_d = '0;
    err_d = 1'b0;
    err_id_d = err_id;
    case (state)
      IDLE: if (|req) begin
        state_d = LAUNCH;
        m_sel_d = win;
        m_data_d = wdata[8*win +: 8];
        m_start_d = 1'b1;
      end
      LAUNCH: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        timer_d = timer + 1'b1;
        if (m_done || timer == TW'(TIMEOUT - 1)) begin
          ack_d = m_done ? NUM_REQ'(1) << m_sel : '0;
          err_d = !m_done;
          err_id_d = m_done ? err_id : m_sel;
          rr_d = nxt;
          gcnt_d = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      default: begin
        gcnt_d = gcnt + 1'b1;
        if (gcnt == GW'(GAP_CYCLES - 1)) state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      timer <= '0;
      gcnt <= '0;
      m_start <= 1'b0;
      m_data <= '0;
      m_sel <= '0;
      ack <= '0;
      err <= 1'b0;
      err_id <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      rr_ptr <= rr_d;
      timer <= timer_d;
      gcnt <= gcnt_d;
      m_start <= m_start_d;
      m_data <= m_data_d;
      m_sel <= m_sel_d;
      ack <= ack_d;
      err <= err_d;
      err_id <= err_id_d;
      busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: scoreboard bench with a behavioural SPI engine for spi_txn_arbiter
module tb_spi_txn_arbiter;
  logic clk = 1'b0, rst = 1'b1, m_done = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] wdata = '0;
  logic [3:0] ack;
  logic err, busy, m_start;
  logic [1:0] err_id, m_sel;
  logic [7:0] m_data;
  int checks = 0, errors = 0;
  typedef struct {logic [1:0] sel; logic [7:0] data;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  spi_txn_arbiter #(.NUM_REQ(4), .GAP_CYCLES(8), .TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .ack(ack), .err(err), .err_id(err_id),
    .busy(busy), .m_start(m_start), .m_data(m_data), .m_sel(m_sel), .m_done(m_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_grant(input logic [1:0] s);
    exp_t e;
    e.sel = s;
    e.data = wdata[8*s +: 8];
    sb.push_back(e);
  endtask
  // engine model: d = cycles after start-observation at which done is raised
  task automatic serve(input int d, input bit give_done);
    exp_t e;
    bit seen = 0, bad = 0;
    e.sel = '0;
    e.data = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = m_start;
    end
    check("start_seen", {31'b0, seen}, 1);
    check("sb_pending", {31'b0, sb.size() != 0}, 1);
    if (sb.size() != 0) e = sb.pop_front();
    check("m_sel", m_sel, e.sel);
    check("m_data", m_data, e.data);
    tick();
    check("start_pulse", m_start, 0);
    if (give_done) begin
      repeat (d - 1) tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("ack", ack, 4'b1 << e.sel);
      check("err_on_done", err, 0);
    end else begin
      repeat (255) begin
        tick();
        bad |= err | (|ack);
      end
      check("no_early_err", {31'b0, bad}, 0);
      tick();
      check("err", err, 1);
      check("err_id", err_id, e.sel);
      check("ack_on_err", ack, 0);
    end
    tick();
    check("pulse_end", {err, ack}, 0);
    repeat (6) tick();
    check("busy_gap", busy, 1);
    tick();
    check("busy_idle", busy, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_out"}, {m_start, m_data, m_sel, ack, err, err_id, busy}, 0);
  endtask
  initial begin
    bit bad = 0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    wdata = 32'h000000EA;
    req = 4'b0001;
    expect_grant(0);
    serve(20, 1);
    req = '0;
    do_reset();
    wdata = 32'h00330011;
    req = 4'b0101;
    for (int i = 0; i < 4; i++) expect_grant(i[0] ? 2'd2 : 2'd0);
    for (int i = 0; i < 4; i++) serve(3 + i, 1);
    req = '0;
    do_reset();
    wdata = 32'hD4C3B2A1;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) expect_grant(2'(i));
    for (int i = 0; i < 8; i++) serve(1 + i, 1);
    req = 4'b0010;
    expect_grant(1);
    serve(0, 0);
    req = 4'b1111;
    expect_grant(2);
    serve(2, 1);
    req = 4'b0001;
    expect_grant(0);
    serve(256, 1);
    req = '0;
    wdata = 32'h44332211;
    req = 4'b0100;
    expect_grant(2);
    for (int k = 0; k < 40 && !m_start; k++) tick();
    check("rst_start", m_sel, sb.pop_front().sel);
    repeat (5) tick();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    check_reset_vals("mid_rst");
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    repeat (4) begin
      tick();
      bad |= err | (|ack) | busy | m_start;
    end
    check("stale_done_ignored", {31'b0, bad}, 0);
    req = 4'b0011;
    expect_grant(0);
    serve(3, 1);
    req = '0;
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal;
  end
endmodule
